// File: rtl/key_filter.sv
// key_filter: multi-channel key debouncer with press/release,
// long-press and auto-repeat pulse generation.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        async-assert active-low reset
//   ori_signal   raw asynchronous key inputs, one per channel
//   level        debounced pressed state per channel
//   pos_signal   one-clk pulse when a press is accepted
//   neg_signal   one-clk pulse when a release is accepted
//   long_signal  one-clk pulse when the hold time is reached
//   rep_signal   one-clk auto-repeat pulse after long press
module key_filter #(
   parameter int N_CH         = 4,
   parameter int TICK_DIV     = 100000,
   parameter int STABLE_CNT   = 3,
   parameter int HOLD_TICKS   = 50,
   parameter int REPEAT_TICKS = 10,
   parameter bit REPEAT_EN    = 1'b1,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] ori_signal,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] pos_signal,
   output logic [N_CH-1:0] neg_signal,
   output logic [N_CH-1:0] long_signal,
   output logic [N_CH-1:0] rep_signal
);

   // Counter widths: each counter only ever holds values up to
   // its terminal count, so none of them can wrap.
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CNT - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
   localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_TICKS - 1);

   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;
   logic [N_CH-1:0] w_samp;
   logic [TW-1:0]   r_tick_cnt;
   logic            w_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= ori_signal;
         r_sync2 <= r_sync1;
      end
   end

   assign w_samp = r_sync2 ^ {N_CH{ACTIVE_LOW}};

   assign w_tick = (r_tick_cnt == TICK_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic          r_lvl;
      logic          r_pos;
      logic          r_neg;
      logic          r_long;
      logic          r_rep;
      logic [SW-1:0] r_stab;
      logic [HW-1:0] r_hold;
      logic [RW-1:0] r_rep_cnt;
      logic          w_diff;
      logic          w_flip;

      assign w_diff = w_samp[g] ^ r_lvl;
      // Last of STABLE_CNT consecutive differing ticks.
      assign w_flip = w_tick & w_diff & (r_stab == STAB_MAX);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_lvl     <= 1'b0;
            r_pos     <= 1'b0;
            r_neg     <= 1'b0;
            r_long    <= 1'b0;
            r_rep     <= 1'b0;
            r_stab    <= '0;
            r_hold    <= '0;
            r_rep_cnt <= '0;
         end else begin
            r_pos  <= w_flip & ~r_lvl;
            r_neg  <= w_flip & r_lvl;
            r_long <= 1'b0;
            r_rep  <= 1'b0;

            if (w_tick) begin
               if (!w_diff || w_flip) begin
                  r_stab <= '0;
               end else begin
                  r_stab <= r_stab + 1'b1;
               end
            end

            if (w_flip) begin
               r_lvl <= ~r_lvl;
            end

            // Release wins over any long/repeat due on that tick.
            if (w_flip && r_lvl) begin
               r_hold    <= '0;
               r_rep_cnt <= '0;
            end else if (w_tick && r_lvl) begin
               if (r_hold != HOLD_MAX) begin
                  r_hold <= r_hold + 1'b1;
                  if (r_hold == HOLD_PRE) begin
                     r_long <= 1'b1;
                  end
               end else if (REPEAT_EN) begin
                  if (r_rep_cnt == REP_MAX) begin
                     r_rep_cnt <= '0;
                     r_rep     <= 1'b1;
                  end else begin
                     r_rep_cnt <= r_rep_cnt + 1'b1;
                  end
               end
            end
         end
      end

      assign level[g]       = r_lvl;
      assign pos_signal[g]  = r_pos;
      assign neg_signal[g]  = r_neg;
      assign long_signal[g] = r_long;
      assign rep_signal[g]  = r_rep;
   end

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: scoreboard bench for key_filter.
// Two instances: active-high keys and active-low keys.
module tb_key_filter;

   typedef struct {
      int         cyc;
      logic [1:0] pos;
      logic [1:0] neg;
      logic [1:0] lng;
      logic [1:0] rep;
   } evt_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] ori_a;
   logic [1:0] ori_b;
   logic [1:0] lvl_a, pos_a, neg_a, lng_a, rep_a;
   logic [1:0] lvl_b, pos_b, neg_b, lng_b, rep_b;

   int   cyc;
   int   vectors;
   int   errors;
   evt_t q_a[$];
   evt_t q_b[$];

   key_filter #(
      .N_CH(2), .TICK_DIV(4), .STABLE_CNT(3), .HOLD_TICKS(8),
      .REPEAT_TICKS(2), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .ori_signal(ori_a),
      .level(lvl_a), .pos_signal(pos_a), .neg_signal(neg_a),
      .long_signal(lng_a), .rep_signal(rep_a)
   );

   key_filter #(
      .N_CH(2), .TICK_DIV(4), .STABLE_CNT(3), .HOLD_TICKS(8),
      .REPEAT_TICKS(2), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .ori_signal(ori_b),
      .level(lvl_b), .pos_signal(pos_b), .neg_signal(neg_b),
      .long_signal(lng_b), .rep_signal(rep_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; tick edges are multiples of 4.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic evt_t mk(input int c, input logic [1:0] p,
                               input logic [1:0] n, input logic [1:0] l,
                               input logic [1:0] r);
      evt_t e;
      e.cyc = c; e.pos = p; e.neg = n; e.lng = l; e.rep = r;
      return e;
   endfunction

   task automatic mon_step(input int inst, input logic [1:0] p,
                           input logic [1:0] n, input logic [1:0] l,
                           input logic [1:0] r);
      evt_t e;
      int   len;
      len = (inst == 0) ? q_a.size() : q_b.size();
      while (len > 0) begin
         e = (inst == 0) ? q_a[0] : q_b[0];
         if (e.cyc >= cyc) break;
         if (inst == 0) void'(q_a.pop_front());
         else           void'(q_b.pop_front());
         len--;
         vectors++;
         errors++;
         $display("FAIL missed_evt inst%0d: no pulse seen, required at cyc %0d pos=%b neg=%b long=%b rep=%b",
                  inst, e.cyc, e.pos, e.neg, e.lng, e.rep);
      end
      if ((p | n | l | r) != 2'b00) begin
         vectors++;
         if (len == 0) begin
            errors++;
            $display("FAIL unexpected_evt inst%0d: cyc %0d pos=%b neg=%b long=%b rep=%b, required none",
                     inst, cyc, p, n, l, r);
         end else begin
            if (inst == 0) e = q_a.pop_front();
            else           e = q_b.pop_front();
            if (e.cyc != cyc || e.pos != p || e.neg != n ||
                e.lng != l || e.rep != r) begin
               errors++;
               $display("FAIL evt inst%0d: got cyc %0d pos=%b neg=%b long=%b rep=%b, required cyc %0d pos=%b neg=%b long=%b rep=%b",
                        inst, cyc, p, n, l, r, e.cyc, e.pos, e.neg, e.lng, e.rep);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon_step(0, pos_a, neg_a, lng_a, rep_a);
         mon_step(1, pos_b, neg_b, lng_b, rep_b);
      end
   end

   task automatic chk(input string nm, input logic [1:0] act,
                      input logic [1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, required %b", nm, act, exp);
      end
   endtask

   task automatic wait_cyc(input int t);
      int n;
      n = 0;
      while (cyc < t && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (cyc < t) begin
         vectors++;
         errors++;
         $display("FAIL wait_cyc: reached cyc %0d, required %0d", cyc, t);
      end
   endtask

   // Park on the negedge right after a tick edge.
   task automatic align(output int d);
      @(negedge clk);
      for (int i = 0; i < 8 && (cyc % 4) != 0; i++) @(negedge clk);
      d = cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      vectors = 0;
      errors  = 0;
      rst_n   = 1'b0;
      ori_a   = 2'b00;
      ori_b   = 2'b11;
      repeat (3) @(negedge clk);
      chk("rst_level_a", lvl_a, 2'b00);
      chk("rst_pulses_a", pos_a | neg_a | lng_a | rep_a, 2'b00);
      chk("rst_level_b", lvl_b, 2'b00);
      chk("rst_pulses_b", pos_b | neg_b | lng_b | rep_b, 2'b00);
      rst_n = 1'b1;

      // Clean press, long press, repeats, release
      align(d);
      ori_a = 2'b01;
      q_a.push_back(mk(d + 12, 2'b01, 2'b00, 2'b00, 2'b00));
      q_a.push_back(mk(d + 44, 2'b00, 2'b00, 2'b01, 2'b00));
      q_a.push_back(mk(d + 52, 2'b00, 2'b00, 2'b00, 2'b01));
      q_a.push_back(mk(d + 60, 2'b00, 2'b00, 2'b00, 2'b01));
      q_a.push_back(mk(d + 68, 2'b00, 2'b00, 2'b00, 2'b01));
      q_a.push_back(mk(d + 76, 2'b00, 2'b01, 2'b00, 2'b00));
      wait_cyc(d + 11);
      chk("press_level_before", lvl_a, 2'b00);
      wait_cyc(d + 13);
      chk("press_level", lvl_a, 2'b01);
      wait_cyc(d + 64);
      ori_a = 2'b00;
      wait_cyc(d + 75);
      chk("release_level_before", lvl_a, 2'b01);
      wait_cyc(d + 77);
      chk("release_level", lvl_a, 2'b00);
      wait_cyc(d + 100);

      // Glitch of two ticks, then a fresh full press
      align(d);
      ori_a = 2'b01;
      wait_cyc(d + 8);
      ori_a = 2'b00;
      wait_cyc(d + 24);
      chk("glitch_level", lvl_a, 2'b00);
      align(d);
      ori_a = 2'b01;
      q_a.push_back(mk(d + 12, 2'b01, 2'b00, 2'b00, 2'b00));
      wait_cyc(d + 12);
      ori_a = 2'b00;
      q_a.push_back(mk(d + 24, 2'b00, 2'b01, 2'b00, 2'b00));
      wait_cyc(d + 30);

      // Simultaneous press and release on both channels
      align(d);
      ori_a = 2'b11;
      q_a.push_back(mk(d + 12, 2'b11, 2'b00, 2'b00, 2'b00));
      wait_cyc(d + 12);
      ori_a = 2'b00;
      q_a.push_back(mk(d + 24, 2'b00, 2'b11, 2'b00, 2'b00));
      wait_cyc(d + 30);

      // Reset while ch1 is held and ch0 is mid-debounce
      align(d);
      ori_a = 2'b10;
      q_a.push_back(mk(d + 12, 2'b10, 2'b00, 2'b00, 2'b00));
      wait_cyc(d + 12);
      ori_a = 2'b11;
      wait_cyc(d + 21);
      chk("pre_reset_level", lvl_a, 2'b10);
      rst_n = 1'b0;
      #1;
      chk("midrst_level", lvl_a, 2'b00);
      chk("midrst_pulses", pos_a | neg_a | lng_a | rep_a, 2'b00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      q_a.push_back(mk(12, 2'b11, 2'b00, 2'b00, 2'b00));
      wait_cyc(11);
      chk("postrst_level_before", lvl_a, 2'b00);
      wait_cyc(12);
      ori_a = 2'b00;
      q_a.push_back(mk(24, 2'b00, 2'b11, 2'b00, 2'b00));
      wait_cyc(30);

      // Active-low instance: drive ch0 to 0 to press
      align(d);
      chk("al_idle_level", lvl_b, 2'b00);
      ori_b = 2'b10;
      q_b.push_back(mk(d + 12, 2'b01, 2'b00, 2'b00, 2'b00));
      wait_cyc(d + 13);
      chk("al_press_level", lvl_b, 2'b01);
      wait_cyc(d + 16);
      ori_b = 2'b11;
      q_b.push_back(mk(d + 28, 2'b00, 2'b01, 2'b00, 2'b00));
      wait_cyc(d + 29);
      chk("al_release_level", lvl_b, 2'b00);
      wait_cyc(d + 60);

      chk("queue_a_drained", 2'(q_a.size() > 0 ? 1 : 0), 2'b00);
      chk("queue_b_drained", 2'(q_b.size() > 0 ? 1 : 0), 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels; legal range 1..32.
REQ-002 Parameter TICK_DIV, default 100000: clk cycles per sample tick; legal range 1 and up.
REQ-003 Parameter STABLE_CNT, default 3: consecutive differing samples needed to accept a new level; legal range 1 and up.
REQ-004 Parameter HOLD_TICKS, default 50: ticks held before long-press fires; legal range 1 and up.
REQ-005 Parameter REPEAT_TICKS, default 10: tick interval between auto-repeat pulses; legal range 1 and up.
REQ-006 Parameter REPEAT_EN, default 1: 1 enables auto-repeat, 0 disables it.
REQ-007 Parameter ACTIVE_LOW, default 0: 1 inverts raw inputs after synchronisation, for pressed-equals-0 keys.
REQ-008 clk  input  1  sole clock; all state changes on its rising edge.
REQ-009 rst_n  input  1  reset, asynchronous assert, active-low; synchronous release to clk.
REQ-010 ori_signal  input  N_CH  raw asynchronous key inputs, one bit per channel.
REQ-011 level  output  N_CH  debounced pressed state per channel, registered.
REQ-012 pos_signal  output  N_CH  one-clk press pulse per channel (accepted 0->1 transition).
REQ-013 neg_signal  output  N_CH  one-clk release pulse per channel (accepted 1->0 transition).
REQ-014 long_signal  output  N_CH  one-clk long-press pulse per channel.
REQ-015 rep_signal  output  N_CH  one-clk auto-repeat pulse per channel.

Function
REQ-016 Each ori_signal bit SHALL pass a 2-flop synchroniser, then the ACTIVE_LOW inversion, before any use; this adds 2 clk cycles of latency.
REQ-017 A shared tick counter SHALL run 0..TICK_DIV-1 and wrap to 0; tick is high for one clk in the cycle where count equals TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-018 On each tick, a channel whose synchronised sample differs from level SHALL increment its stability counter; if the sample equals level, the counter clears to 0.
REQ-019 When the stability counter reaches STABLE_CNT (that is, STABLE_CNT consecutive differing ticks), level SHALL toggle on the clk edge closing that tick, and the counter SHALL clear.
REQ-020 pos_signal or neg_signal SHALL assert for exactly the one clk cycle in which the new level first appears; they are never both high on one channel.
REQ-021 A hold counter per channel SHALL increment on every tick while level=1, saturating at HOLD_TICKS; it clears on the edge where level becomes 0.
REQ-022 long_signal SHALL pulse once, for one clk, on the tick where the hold count becomes HOLD_TICKS; it never fires again until release and a fresh press.
REQ-023 With REPEAT_EN=1, after long_signal, rep_signal SHALL pulse one clk every REPEAT_TICKS ticks while level=1, with the first pulse REPEAT_TICKS ticks after long_signal. With REPEAT_EN=0, rep_signal stays 0.
REQ-024 Release (level 1->0) SHALL clear the hold and repeat counters in the same edge; no long or repeat pulse occurs in that cycle or later.
REQ-025 Channels SHALL be fully independent; any combination of channels may pulse in the same cycle.
REQ-026 Counter widths SHALL be sized from the parameters so that no counter wraps; the tick counter wraps only at TICK_DIV-1.

Reset
REQ-027 While rst_n=0, SHALL force synchronisers, tick counter, stability, hold and repeat counters, level, and all pulse outputs to 0, regardless of clk.
REQ-028 Reset asserted mid-press or mid-debounce SHALL discard partial counts; after release, a held key needs a full STABLE_CNT ticks again before pos_signal.

Verification
Bench parameters: N_CH=2, TICK_DIV=4, STABLE_CNT=3, HOLD_TICKS=8, REPEAT_TICKS=2, REPEAT_EN=1, ACTIVE_LOW=0.
REQ-029 Clean press: ch0 driven to 1 and held -> level[0]=1 and a single 1-clk pos_signal[0] on the 3rd tick sampling 1; ch1 stays 0.
REQ-030 Glitch: ch0 high for 2 ticks, then low -> no pos_signal, level[0] stays 0, stability counter back to 0.
REQ-031 Long press: ch0 held -> long_signal[0] 8 ticks after pos_signal, then rep_signal[0] at +2, +4, +6 ticks; release -> neg_signal[0] 3 ticks after the input falls, with no further rep_signal.
REQ-032 Simultaneous: both channels pressed on the same clk -> pos_signal[1:0]=2'b11 in the same cycle.
REQ-033 Reset mid-debounce: rst_n pulsed low after 2 high ticks on ch0 -> all outputs 0 at once; with the input still high, pos_signal arrives 3 full ticks after rst_n rises.
REQ-034 ACTIVE_LOW=1 rerun: an idle input of 1 gives no pulses; driving 0 produces the REQ-029 behaviour.
